// File: rtl/wb_master_arbiter.sv
// Round-robin arbiter sharing one Wishbone crossbar master port between two masters,
// with a per-transfer ACK timeout that errors the owner and drains the bus.
//
// state | meaning
// IDLE  | no owner, crossbar sees CYC/STB low, masters stalled
// OWN0  | M0 drives the crossbar port
// OWN1  | M1 drives the crossbar port
// DRAIN | timed out; owner held off the bus until it drops CYC
module wb_master_arbiter #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  WBM_CYC,
  input  logic [1:0]  WBM_STB,
  input  logic [1:0]  WBM_WE,
  input  logic [63:0] WBM_ADDR,
  input  logic [15:0] WBM_WDATA,
  input  logic [1:0]  WBM_SEL,
  output logic [1:0]  WBM_STALL,
  output logic [1:0]  WBM_ACK,
  output logic [7:0]  WBM_RDATA,
  output logic [1:0]  WBM_ERR,
  output logic        WBX_CYC,
  output logic        WBX_STB,
  output logic        WBX_WE,
  output logic [31:0] WBX_ADDR,
  output logic [7:0]  WBX_WDATA,
  output logic        WBX_SEL,
  input  logic        WBX_STALL,
  input  logic        WBX_ACK,
  input  logic [7:0]  WBX_RDATA,
  input  logic        WBX_ERR
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_EN ? TIMEOUT_CYCLES - 1 : 0);

  state_t           state;
  logic             owner;
  logic             last;
  logic [CNT_W-1:0] cnt;
  logic             pend;
  logic             tmo_err;

  logic [1:0] req;
  logic       grant_idx;
  logic       own_act;
  logic       xfer_done;

  assign req       = WBM_CYC & WBM_STB;
  assign grant_idx = (req == 2'b11) ? ~last : req[1];
  assign own_act   = (state == OWN0) || (state == OWN1);
  assign xfer_done = WBX_ACK | WBX_ERR;
  assign WBM_RDATA = WBX_RDATA;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      owner   <= 1'b0;
      last    <= 1'b1;
      cnt     <= '0;
      pend    <= 1'b0;
      tmo_err <= 1'b0;
    end else begin
      tmo_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt  <= '0;
          pend <= 1'b0;
          if (req != 2'b00) begin
            owner <= grant_idx;
            state <= grant_idx ? OWN1 : OWN0;
          end
        end
        OWN0, OWN1: begin
          if (!WBM_CYC[owner]) begin
            state <= IDLE;
            last  <= owner;
          end else if (xfer_done) begin
            // a response in the timeout cycle still counts as a normal completion
            cnt  <= '0;
            pend <= 1'b0;
          end else if (TMO_EN && (pend || WBX_STB)) begin
            pend <= 1'b1;
            if (cnt == TMO_LAST) begin
              tmo_err <= 1'b1;
              cnt     <= '0;
              state   <= DRAIN;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          if (!WBM_CYC[owner]) begin
            state <= IDLE;
            last  <= owner;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    WBX_CYC   = 1'b0;
    WBX_STB   = 1'b0;
    WBX_WE    = 1'b0;
    WBX_ADDR  = '0;
    WBX_WDATA = '0;
    WBX_SEL   = 1'b0;
    WBM_STALL = 2'b11;
    WBM_ACK   = 2'b00;
    WBM_ERR   = 2'b00;
    if (own_act) begin
      WBX_CYC          = WBM_CYC[owner];
      WBX_STB          = WBM_STB[owner];
      WBX_WE           = WBM_WE[owner];
      WBX_ADDR         = owner ? WBM_ADDR[63:32] : WBM_ADDR[31:0];
      WBX_WDATA        = owner ? WBM_WDATA[15:8] : WBM_WDATA[7:0];
      WBX_SEL          = WBM_SEL[owner];
      WBM_STALL[owner] = WBX_STALL;
      WBM_ACK[owner]   = WBX_ACK;
      WBM_ERR[owner]   = WBX_ERR;
    end
    // tmo_err is only ever set on the edge into DRAIN, so owner is still valid
    if (tmo_err) WBM_ERR[owner] = 1'b1;
  end

endmodule
